// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire sensor controller.
package dht11_pkg;

  typedef enum logic [3:0] {
    ST_STARTUP, ST_IDLE, ST_START, ST_WAIT_ACK, ST_RESP_LOW,
    ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_CHECK, ST_DONE
  } state_e;

  localparam int unsigned DEF_CLK_HZ            = 100_000_000;
  localparam int unsigned DEF_STARTUP_CYCLES    = 100_000_000;
  localparam int unsigned DEF_START_LOW_CYCLES  = 1_800_000;
  localparam int unsigned DEF_BIT_THRESH_CYCLES = 4_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 20_000;

  localparam int FRAME_BITS = 40;
  localparam int B_HUM_INT  = 4;
  localparam int B_HUM_DEC  = 3;
  localparam int B_TMP_INT  = 2;
  localparam int B_TMP_DEC  = 1;
  localparam int B_CSUM     = 0;

  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f, input int idx);
    return f[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous sensor line.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] ff;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= {2{RST_VAL}};
    else        ff <= {ff[0], d};

  assign q = ff[1];
endmodule

// File: rtl/dht11.sv
// DHT11 controller: start pulse, 40-bit pulse-width frame decode, checksum,
// and a 16-bit {temp_int, hum_int} result with a ready flag.
module dht11 import dht11_pkg::*; #(
  parameter int unsigned CLK_HZ            = DEF_CLK_HZ,
  parameter int unsigned STARTUP_CYCLES    = DEF_STARTUP_CYCLES,
  parameter int unsigned START_LOW_CYCLES  = DEF_START_LOW_CYCLES,
  parameter int unsigned BIT_THRESH_CYCLES = DEF_BIT_THRESH_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [15:0] uart_tx,
  output logic        ready,
  inout  wire         dht11_data
);
  localparam int unsigned M1      = (START_LOW_CYCLES > TIMEOUT_CYCLES) ? START_LOW_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (M1 > BIT_THRESH_CYCLES) ? M1 : BIT_THRESH_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int IW = $clog2(STARTUP_CYCLES + 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_LOW_CYCLES - 1);
  localparam logic [CW-1:0] TMO        = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] THRESH     = CW'(BIT_THRESH_CYCLES);
  localparam logic [IW-1:0] INT_LEN    = IW'(STARTUP_CYCLES);

  state_e                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           int_cnt;
  logic [5:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    line_raw, line_s, line_q, rise, fall;
  logic                    drive_low, int_done, in_wait, tmo, bit_val, start_go, take_bit, csum_ok;
  logic [7:0]              csum;

  // Anything but a solid 0 (including z) reads as the pulled-up high level.
  assign line_raw = (dht11_data !== 1'b0);
  assign dht11_data = drive_low ? 1'b0 : 1'bz;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(line_raw), .q(line_s));

  assign rise     = line_s & ~line_q;
  assign fall     = ~line_s & line_q;
  assign int_done = (int_cnt >= INT_LEN);
  assign tmo      = in_wait && (cnt >= TMO);
  assign bit_val  = (cnt > THRESH);
  assign start_go = (state == ST_IDLE) && (state_nxt == ST_START);
  assign take_bit = (state == ST_BIT_HIGH) && fall;
  assign csum     = frame_byte(shreg, B_HUM_INT) + frame_byte(shreg, B_HUM_DEC)
                  + frame_byte(shreg, B_TMP_INT) + frame_byte(shreg, B_TMP_DEC);
  assign csum_ok  = (csum == frame_byte(shreg, B_CSUM));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_STARTUP;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP:   if (int_done) state_nxt = ST_IDLE;
      ST_IDLE:      if (uart_rx && int_done) state_nxt = ST_START;
      ST_START:     if (cnt == START_LAST) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (fall) state_nxt = ST_RESP_LOW;  else if (tmo) state_nxt = ST_IDLE;
      ST_RESP_LOW:  if (rise) state_nxt = ST_RESP_HIGH; else if (tmo) state_nxt = ST_IDLE;
      ST_RESP_HIGH: if (fall) state_nxt = ST_BIT_LOW;   else if (tmo) state_nxt = ST_IDLE;
      ST_BIT_LOW:   if (rise) state_nxt = ST_BIT_HIGH;  else if (tmo) state_nxt = ST_IDLE;
      ST_BIT_HIGH:  if (fall) state_nxt = (bit_cnt == 6'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
                    else if (tmo) state_nxt = ST_IDLE;
      ST_CHECK:     state_nxt = csum_ok ? ST_DONE : ST_IDLE;
      ST_DONE:      if (!uart_rx) state_nxt = ST_IDLE;
      default:      state_nxt = ST_STARTUP;
    endcase
  end

  always_comb begin
    drive_low = 1'b0;
    ready     = 1'b0;
    in_wait   = 1'b0;
    case (state)
      ST_START: drive_low = 1'b1;
      ST_DONE:  ready     = 1'b1;
      ST_WAIT_ACK, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH: in_wait = 1'b1;
      default: ;
    endcase
  end

  // cnt measures time spent in the current state; it restarts on every transition.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line_q  <= 1'b1;
      cnt     <= '0;
      int_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      line_q <= line_s;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 1'b1;
      if (start_go)           int_cnt <= '0;
      else if (!int_done)     int_cnt <= int_cnt + 1'b1;
      if (start_go) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {shreg[FRAME_BITS-2:0], bit_val};
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                           uart_tx <= '0;
    else if (state == ST_CHECK && csum_ok) uart_tx <= {frame_byte(shreg, B_TMP_INT), frame_byte(shreg, B_HUM_INT)};

endmodule

// File: tb/tb_dht11.sv
// Randomized bench for dht11: a behavioural sensor drives frames and the
// expected result comes from the frame bytes and checksum rule.
module tb_dht11;
  localparam int STUP = 3000;
  localparam int SLOW = 180;
  localparam int THR  = 40;
  localparam int TMO  = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b0;
  logic        sens_low = 1'b0;
  logic [15:0] uart_tx;
  logic        ready;
  wire         dht11_data;
  wire         line_hi = (dht11_data !== 1'b0);

  pullup (dht11_data);
  assign dht11_data = sens_low ? 1'b0 : 1'bz;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hw[40];
  logic [15:0] exp_tx = '0;

  dht11 #(
    .CLK_HZ(1_000_000), .STARTUP_CYCLES(STUP), .START_LOW_CYCLES(SLOW),
    .BIT_THRESH_CYCLES(THR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .ready(ready), .dht11_data(dht11_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic csum_ok(input logic [39:0] f);
    int s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (s % 256) == int'(f[7:0]);
  endfunction

  // mode 0: random widths, 1: nominal 28/70, 2: near-threshold 38/42
  task automatic gen_hw(input logic [39:0] f, input int mode);
    for (int i = 0; i < 40; i++) begin
      case (mode)
        1:       hw[i] = f[39-i] ? 70 : 28;
        2:       hw[i] = f[39-i] ? 42 : 38;
        default: hw[i] = f[39-i] ? int'($urandom_range(72, 44)) : int'($urandom_range(37, 24));
      endcase
    end
  endtask

  // Waits for the host start pulse; returns its first-low cycle and width.
  task automatic wait_start(input int limit, output int t0, output int w);
    int n = 0;
    t0 = -1;
    w  = 0;
    while (line_hi && n < limit) begin @(negedge clk); n++; end
    if (line_hi) begin
      chk("start_seen", 0, 1);
      return;
    end
    t0 = cyc;
    while (!line_hi && w < 2*SLOW) begin w++; @(negedge clk); end
  endtask

  task automatic send_frame(input int nbits);
    repeat (20) @(negedge clk);
    sens_low = 1'b1; repeat (80) @(negedge clk);
    sens_low = 1'b0; repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sens_low = 1'b1; repeat (50) @(negedge clk);
      sens_low = 1'b0; repeat (hw[i]) @(negedge clk);
    end
    if (nbits == 40) begin
      sens_low = 1'b1; repeat (50) @(negedge clk);
      sens_low = 1'b0;
    end
  endtask

  task automatic do_meas(input logic [39:0] f, input int mode, input int t_ref);
    int   t0, w, n;
    logic saw;
    uart_rx = 1'b1;
    wait_start(STUP + 500, t0, w);
    if (t0 < 0) begin uart_rx = 1'b0; return; end
    chk("start_width", w, SLOW);
    if (t_ref >= 0) chk("startup_gap", (t0 - t_ref >= STUP) && (t0 - t_ref <= STUP + 4), 1);
    if (!csum_ok(f)) uart_rx = 1'b0;
    gen_hw(f, mode);
    send_frame(40);
    if (csum_ok(f)) begin
      exp_tx = {f[23:16], f[39:32]};
      n = 0;
      while (!ready && n < 200) begin @(negedge clk); n++; end
      chk("ready_set", ready, 1);
      chk("tx_value", uart_tx, exp_tx);
      repeat (5) @(negedge clk);
      chk("ready_held", ready, 1);
      uart_rx = 1'b0;
      @(negedge clk);
      chk("ready_drop", ready, 0);
    end else begin
      saw = 1'b0;
      repeat (40) begin @(negedge clk); saw |= ready; end
      chk("bad_no_ready", saw, 0);
      chk("bad_tx_kept", uart_tx, exp_tx);
      chk("bad_line_rel", line_hi, 1);
    end
  endtask

  initial begin
    logic [39:0] f;
    int          t0, t1, w, t_rel, n;
    logic        saw;

    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 16'h0000);
    chk("rst_ready", ready, 0);
    chk("rst_line", line_hi, 1);
    uart_rx = 1'b1;
    rst_n   = 1'b1;
    t_rel   = cyc;

    do_meas(40'h35_00_18_00_4D, 1, t_rel);
    do_meas(40'h35_00_18_00_4C, 1, -1);

    for (int k = 0; k < 3; k++) begin
      f[39:8] = $urandom;
      f[7:0]  = (k == 2) ? 8'($urandom) : 8'(f[39:32] + f[31:24] + f[23:16] + f[15:8]);
      do_meas(f, 0, -1);
    end

    // Silent sensor: time out, then a held request must wait out the interval.
    uart_rx = 1'b1;
    wait_start(STUP + 500, t0, w);
    chk("silent_start_w", w, SLOW);
    saw = 1'b0;
    repeat (TMO + 40) begin @(negedge clk); saw |= ready; end
    chk("silent_ready", saw, 0);
    chk("silent_line", line_hi, 1);
    chk("silent_tx", uart_tx, exp_tx);
    wait_start(STUP + 500, t1, w);
    chk("interval_gap", (t1 - t0 >= STUP) && (t1 - t0 <= STUP + 4), 1);
    uart_rx = 1'b0;
    repeat (TMO + 40) @(negedge clk);

    do_meas(40'h2A_01_17_05_47, 2, -1);

    // Abort mid-frame (bit 20 high phase) with an asynchronous reset.
    f = 40'h35_00_18_00_4D;
    uart_rx = 1'b1;
    wait_start(STUP + 500, t0, w);
    gen_hw(f, 1);
    send_frame(20);
    sens_low = 1'b1; repeat (50) @(negedge clk);
    sens_low = 1'b0; repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_tx = '0;
    #1;
    chk("midrst_tx", uart_tx, 16'h0000);
    chk("midrst_ready", ready, 0);
    chk("midrst_line", line_hi, 1);
    @(negedge clk);
    rst_n = 1'b1;
    t_rel = cyc;
    do_meas(f, 0, t_rel);

    // Reset during the start pulse must release the line before the next edge.
    uart_rx = 1'b1;
    n = 0;
    while (line_hi && n < STUP + 500) begin @(negedge clk); n++; end
    chk("pulse_seen", line_hi, 0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("startrst_line", line_hi, 1);
    chk("startrst_ready", ready, 0);
    @(negedge clk);
    uart_rx = 1'b0;
    rst_n   = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dht11.md
# dht11

Single-wire DHT11 temperature/humidity sensor controller. On a level request from the UART side it issues the DHT11 start pulse, decodes the sensor's 40-bit pulse-width frame and verifies the checksum. It then presents the 8-bit integral temperature and humidity as one 16-bit word with a `ready` flag. It sits between the DHT11 pin (bidirectional, external pull-up) and the UART front end.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency. All durations below are derived from it.
- `STARTUP_CYCLES`, 100_000_000: sensor settle time after reset, and minimum spacing between start pulses (1 s).
- `START_LOW_CYCLES`, 1_800_000: host start-pulse low time (18 ms).
- `BIT_THRESH_CYCLES`, 4_000: data-bit high time above which the bit is `1` (40 µs).
- `TIMEOUT_CYCLES`, 20_000: maximum time spent waiting for any single sensor edge (200 µs).
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `uart_rx`, in, 1: measurement request, level-sensitive.
- `uart_tx`, out, 16: `[15:8]` temperature integral byte, `[7:0]` humidity integral byte.
- `ready`, out, 1: `uart_tx` holds a fresh, checksum-valid result.
- `dht11_data`, inout, 1: sensor line. The module drives only `0` or `z`.

## Operation
- Line sampling: `dht11_data` passes through a 2-FF synchronizer. Any value other than `0` (including `z`) is treated as high, which models the pull-up.
- States and transitions:
  - STARTUP: count `STARTUP_CYCLES`, then go to IDLE.
  - IDLE: go to START when `uart_rx`=1 and the interval counter has expired.
  - START: drive `0` for `START_LOW_CYCLES`, then release (`z`) and go to WAIT_ACK.
  - WAIT_ACK: wait for the line to go low. Then go to RESP_LOW.
  - RESP_LOW: wait for rise (nominal 80 µs). Then go to RESP_HIGH.
  - RESP_HIGH: wait for fall (nominal 80 µs). Then go to BIT_LOW.
  - BIT_LOW: wait for rise (nominal 50 µs). Then go to BIT_HIGH.
  - BIT_HIGH: count high cycles until fall. The bit is `1` if the count > `BIT_THRESH_CYCLES`, otherwise `0`. Shift the bit into a 40-bit register, MSB first (the first bit received becomes frame bit 39). After 40 bits go to CHECK, otherwise go to BIT_LOW.
  - CHECK: the frame is bytes B4..B0 = hum_int, hum_dec, temp_int, temp_dec, checksum.
    - If `(B4+B3+B2+B1) mod 256 == B0`: load `uart_tx <= {B2, B4}` and go to DONE.
    - Otherwise go to IDLE with `uart_tx` unchanged.
  - DONE: `ready`=1. Go to IDLE once `uart_rx`=0.
- The line is driven (`0`) only in START and released in every other state.
- Timeouts: any wait state exceeding `TIMEOUT_CYCLES` goes to IDLE. `ready` stays 0 and `uart_tx` is unchanged.
- Interval counter: restarts at entry to START and must count `STARTUP_CYCLES` before the next START. A held request therefore produces at most one measurement per second.
- Bit counter is 6 bits. Edge counters are wide enough for `START_LOW_CYCLES`.

## Timing
- Reset values:
  - `uart_tx`=0, `ready`=0, line released, state STARTUP.
  - Counters and shift register cleared.
- Reset asserted mid-operation releases the line asynchronously and aborts the frame.
- Start pulse: low for exactly `START_LOW_CYCLES` clocks, beginning the cycle after the request is seen in IDLE.
- Edge detection latency is 2–3 clocks (synchronizer). Measured pulse widths are affected only by ±1 clock.
- `uart_tx` and `ready` update on the same clock edge, one cycle after the 40th falling edge is detected.
- `ready` stays high while `uart_rx`=1 and falls the cycle after `uart_rx`=0 is sampled.
- `uart_tx` holds its value until the next valid frame.

## Structure
- Package `dht11_pkg` contains:
  - the state enum;
  - default cycle constants and the frame byte-index constants.
- Sub-module `sync_2ff` synchronizes the line input. All other logic stays in one FSM module.

## Test plan
- Reset: hold `rst_n`=0 → `uart_tx`=16'h0000, `ready`=0, `dht11_data`=`z`. Run with `STARTUP_CYCLES` overridden small.
- Valid frame: request `uart_rx`=1. Expect the line low for 18 ms, then released. Sensor responds 80 µs low / 80 µs high, then sends 0x35,0x00,0x18,0x00,0x4D MSB-first (50 µs low; 28 µs high = 0, 70 µs high = 1) → `ready`=1 with `uart_tx`=16'h1835. Drop `uart_rx` → `ready`=0 the next cycle.
- Bad checksum: same frame with last byte 0x4C → `ready` stays 0, `uart_tx` keeps its previous value. A new start pulse occurs only after the interval if the request is held.
- Silent sensor: no response after release → return to IDLE after 200 µs, no `ready`, line released.
- Bit threshold: high times of 38 µs and 42 µs decode as 0 and 1 respectively. Verify via the resulting `uart_tx`.
- Reset during bit 20 of a frame → line released immediately, state STARTUP, `ready`=0, `uart_tx`=0.
